// File: rtl/dense_pkg.sv
// rtl/dense_pkg.sv - shared types, constants and the output clamp for the dense-layer sequencer
//
// Contents:
//   N_IN_C       taps per neuron supported by the dot-product engine
//   DP_W         engine result width
//   state_t      sequencer state encoding
//   sat_relu32() 64-bit signed result -> 32-bit output word (optional ReLU, then saturate)

package dense_pkg;

   localparam int N_IN_C = 10;
   localparam int DP_W   = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_START,
      ST_ACK,
      ST_WAIT,
      ST_WRITE,
      ST_DONE
   } state_t;

   // The value fits in 32 bits exactly when bits [63:31] are all equal;
   // otherwise the sign bit picks which rail to clamp to.
   function automatic logic [31:0] sat_relu32(input logic [DP_W-1:0] r, input logic relu_en);
      logic [31:0] res;
      if (relu_en && r[DP_W-1]) begin
         res = '0;
      end else if ((r[DP_W-1:31] == {(DP_W-31){1'b0}}) || (r[DP_W-1:31] == {(DP_W-31){1'b1}})) begin
         res = r[31:0];
      end else if (r[DP_W-1]) begin
         res = 32'h8000_0000;
      end else begin
         res = 32'h7FFF_FFFF;
      end
      return res;
   endfunction

endpackage

// File: rtl/sat_relu_32.sv
// rtl/sat_relu_32.sv - combinational 64->32 signed saturation with optional ReLU
//
// Ports:
//   result   in   DP_W  signed engine result
//   relu_en  in   1     1 = negative results become 0
//   data     out  32    clamped output word

module sat_relu_32
   import dense_pkg::*;
(
   input  logic [DP_W-1:0] result,
   input  logic            relu_en,
   output logic [31:0]     data
);

   assign data = sat_relu32(result, relu_en);

endmodule

// File: rtl/dense_layer_seq.sv
// rtl/dense_layer_seq.sv - sequences one dense layer of neurons through the 10-tap dot-product engine
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   cmd_start_i, relu_en_i, act_i      layer command, ReLU enable and activations (latched on accept)
//   cmd_busy_o, cmd_done_o, err_o      layer status; err_o is a sticky engine timeout
//   wmem_rd_o, wmem_addr_o             weight memory read strobe/address
//   wmem_rdata_i                       weight memory data, valid one cycle after the strobe
//   dp_a_o, dp_b_o, dp_c_o, dp_start_o engine operands and start
//   dp_busy_i, dp_result_valid_i       engine handshake
//   dp_result_i                        engine signed result
//   out_we_o, out_addr_o, out_data_o   output buffer write port

module dense_layer_seq
   import dense_pkg::*;
#(
   parameter int N_IN    = N_IN_C,
   parameter int N_OUT   = 4,
   parameter int AW      = 9,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_start_i,
   input  logic                 relu_en_i,
   input  logic [N_IN*32-1:0]   act_i,
   output logic                 cmd_busy_o,
   output logic                 cmd_done_o,
   output logic                 err_o,
   output logic                 wmem_rd_o,
   output logic [AW-1:0]        wmem_addr_o,
   input  logic [31:0]          wmem_rdata_i,
   output logic [N_IN*32-1:0]   dp_a_o,
   output logic [N_IN*32-1:0]   dp_b_o,
   output logic [31:0]          dp_c_o,
   output logic                 dp_start_o,
   input  logic                 dp_busy_i,
   input  logic                 dp_result_valid_i,
   input  logic [DP_W-1:0]      dp_result_i,
   output logic                 out_we_o,
   output logic [5:0]           out_addr_o,
   output logic [31:0]          out_data_o
);

   localparam int KW = $clog2(N_IN + 2);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t          state;
   logic [KW-1:0]   fk;        // cycle index inside FETCH, 0..N_IN+1
   logic [5:0]      n;         // current neuron
   logic            relu_q;
   logic [TW-1:0]   tcnt;      // cycles spent in ACK+WAIT
   logic [31:0]     sat_data;

   sat_relu_32 u_sat (
      .result  (dp_result_i),
      .relu_en (relu_q),
      .data    (sat_data)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         fk          <= '0;
         n           <= '0;
         relu_q      <= 1'b0;
         tcnt        <= '0;
         cmd_busy_o  <= 1'b0;
         cmd_done_o  <= 1'b0;
         err_o       <= 1'b0;
         wmem_rd_o   <= 1'b0;
         wmem_addr_o <= '0;
         dp_a_o      <= '0;
         dp_b_o      <= '0;
         dp_c_o      <= '0;
         dp_start_o  <= 1'b0;
         out_we_o    <= 1'b0;
         out_addr_o  <= '0;
         out_data_o  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_start_i) begin
                  dp_a_o      <= act_i;
                  relu_q      <= relu_en_i;
                  err_o       <= 1'b0;
                  n           <= '0;
                  cmd_busy_o  <= 1'b1;
                  fk          <= '0;
                  wmem_rd_o   <= 1'b1;
                  wmem_addr_o <= '0;
                  state       <= ST_FETCH;
               end
            end

            // Reads go out on fk = 0..N_IN; data for read j lands on fk = j+1,
            // so the last word (bias) is captured on fk = N_IN+1.
            ST_FETCH: begin
               if (fk != '0) begin
                  if (fk == KW'(N_IN + 1)) begin
                     dp_c_o <= wmem_rdata_i;
                  end else begin
                     dp_b_o[32*(int'(fk)-1) +: 32] <= wmem_rdata_i;
                  end
               end
               if (fk < KW'(N_IN)) begin
                  wmem_rd_o   <= 1'b1;
                  wmem_addr_o <= wmem_addr_o + AW'(1);
               end else begin
                  wmem_rd_o   <= 1'b0;
               end
               if (fk == KW'(N_IN + 1)) begin
                  dp_start_o <= 1'b1;
                  state      <= ST_START;
               end
               fk <= fk + KW'(1);
            end

            ST_START: begin
               dp_start_o <= 1'b0;
               tcnt       <= '0;
               state      <= ST_ACK;
            end

            // result_valid is only looked at in WAIT: in ACK it may still be
            // held high from the previous neuron.
            ST_ACK, ST_WAIT: begin
               if ((state == ST_WAIT) && dp_result_valid_i) begin
                  out_we_o   <= 1'b1;
                  out_addr_o <= n;
                  out_data_o <= sat_data;
                  state      <= ST_WRITE;
               end else if (tcnt == TW'(TIMEOUT - 1)) begin
                  err_o      <= 1'b1;
                  cmd_done_o <= 1'b1;
                  cmd_busy_o <= 1'b0;
                  state      <= ST_DONE;
               end else begin
                  tcnt <= tcnt + TW'(1);
                  if ((state == ST_ACK) && dp_busy_i) begin
                     state <= ST_WAIT;
                  end
               end
            end

            // Weight words are contiguous across neurons, so the next base
            // address is one past the previous bias word.
            ST_WRITE: begin
               out_we_o <= 1'b0;
               if (n == 6'(N_OUT - 1)) begin
                  cmd_done_o <= 1'b1;
                  cmd_busy_o <= 1'b0;
                  state      <= ST_DONE;
               end else begin
                  n           <= n + 6'd1;
                  fk          <= '0;
                  wmem_rd_o   <= 1'b1;
                  wmem_addr_o <= wmem_addr_o + AW'(1);
                  state       <= ST_FETCH;
               end
            end

            ST_DONE: begin
               cmd_done_o <= 1'b0;
               state      <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dense_layer_seq.sv
// tb/tb_dense_layer_seq.sv - randomized self-checking bench for dense_layer_seq

module tb_dense_layer_seq;

   localparam int N_IN  = 10;
   localparam int N_OUT = 4;
   localparam int AW    = 9;
   localparam int TO    = 64;
   localparam int NW    = N_OUT * (N_IN + 1);

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b1;
   logic                 cmd_start_i = 1'b0;
   logic                 relu_en_i = 1'b0;
   logic [N_IN*32-1:0]   act_i = '0;
   logic                 cmd_busy_o, cmd_done_o, err_o;
   logic                 wmem_rd_o;
   logic [AW-1:0]        wmem_addr_o;
   logic [31:0]          wmem_rdata_i = '0;
   logic [N_IN*32-1:0]   dp_a_o, dp_b_o;
   logic [31:0]          dp_c_o;
   logic                 dp_start_o;
   logic                 dp_busy_i = 1'b0;
   logic                 dp_result_valid_i = 1'b0;
   logic [63:0]          dp_result_i = '0;
   logic                 out_we_o;
   logic [5:0]           out_addr_o;
   logic [31:0]          out_data_o;

   dense_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW), .TIMEOUT(TO)) u_dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .cmd_start_i       (cmd_start_i),
      .relu_en_i         (relu_en_i),
      .act_i             (act_i),
      .cmd_busy_o        (cmd_busy_o),
      .cmd_done_o        (cmd_done_o),
      .err_o             (err_o),
      .wmem_rd_o         (wmem_rd_o),
      .wmem_addr_o       (wmem_addr_o),
      .wmem_rdata_i      (wmem_rdata_i),
      .dp_a_o            (dp_a_o),
      .dp_b_o            (dp_b_o),
      .dp_c_o            (dp_c_o),
      .dp_start_o        (dp_start_o),
      .dp_busy_i         (dp_busy_i),
      .dp_result_valid_i (dp_result_valid_i),
      .dp_result_i       (dp_result_i),
      .out_we_o          (out_we_o),
      .out_addr_o        (out_addr_o),
      .out_data_o        (out_data_o)
   );

   always #5 clk_i = ~clk_i;

   // reference state: activations and weight memory contents
   int act_m [N_IN];
   int w_m   [N_OUT][N_IN+1];

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
   endtask

   // golden result: dot product plus bias in plain integer arithmetic, then ReLU/clamp
   function automatic logic [31:0] ref_out(input int n, input bit relu);
      longint s;
      s = longint'(w_m[n][N_IN]);
      for (int i = 0; i < N_IN; i++) s += longint'(act_m[i]) * longint'(w_m[n][i]);
      if (relu && s < 0) return 32'h0;
      if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (s < -64'sd2147483648) return 32'h8000_0000;
      return s[31:0];
   endfunction

   // weight memory: one-cycle read latency, poison when not reading
   always @(posedge clk_i) begin
      if (wmem_rd_o && int'(wmem_addr_o) < NW)
         wmem_rdata_i <= w_m[int'(wmem_addr_o) / (N_IN+1)][int'(wmem_addr_o) % (N_IN+1)];
      else
         wmem_rdata_i <= 32'hDEAD_BEEF;
   end

   // engine: mode 0 = normal, mode 1 = ignores start (never busy, stale valid kept)
   int                 eng_mode = 0;
   int                 eng_cnt = 0;
   int                 hold_bad = 0;
   logic               start_q = 1'b0;
   logic [N_IN*32-1:0] snap_a, snap_b;
   logic [31:0]        snap_c;

   always @(posedge clk_i) begin : engine
      longint s;
      start_q <= dp_start_o;
      if (rst_i) begin
         dp_busy_i         <= 1'b0;
         dp_result_valid_i <= 1'b0;
         dp_result_i       <= '0;
         eng_cnt           <= 0;
      end else if (dp_start_o && !start_q) begin
         if (eng_mode == 0) begin
            dp_busy_i         <= 1'b1;
            dp_result_valid_i <= 1'b0;
            eng_cnt           <= int'($urandom_range(1, 8));
            snap_a            <= dp_a_o;
            snap_b            <= dp_b_o;
            snap_c            <= dp_c_o;
         end
      end else if (dp_busy_i) begin
         if (dp_a_o !== snap_a || dp_b_o !== snap_b || dp_c_o !== snap_c) hold_bad++;
         if (eng_cnt == 0) begin
            s = longint'($signed(dp_c_o));
            for (int i = 0; i < N_IN; i++)
               s += longint'($signed(dp_a_o[32*i +: 32])) * longint'($signed(dp_b_o[32*i +: 32]));
            dp_result_i       <= s;
            dp_busy_i         <= 1'b0;
            dp_result_valid_i <= 1'b1;
         end else begin
            eng_cnt <= eng_cnt - 1;
         end
      end
   end

   // monitor, sampled on the falling edge
   logic [5:0]  wa_q [$];
   logic [31:0] wd_q [$];
   int done_cnt = 0;
   int start_bad = 0;
   int cyc = 0;
   int last_start_cyc = 0;
   int last_done_cyc = 0;
   logic start_prev = 1'b0;

   always @(negedge clk_i) begin
      cyc++;
      if (out_we_o) begin
         wa_q.push_back(out_addr_o);
         wd_q.push_back(out_data_o);
      end
      if (cmd_done_o) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
      if (dp_start_o && start_prev) start_bad++;
      if (dp_start_o) last_start_cyc = cyc;
      start_prev = dp_start_o;
   end

   function automatic logic [31:0] get_wd(input int i);
      if (i < wd_q.size()) return wd_q[i];
      return 32'hxxxx_xxxx;
   endfunction

   task automatic randomize_layer();
      for (int i = 0; i < N_IN; i++) act_m[i] = int'($urandom) >>> 15;
      for (int n = 0; n < N_OUT; n++)
         for (int k = 0; k <= N_IN; k++)
            case ($urandom_range(0, 3))
               0:       w_m[n][k] = 0;
               1:       w_m[n][k] = int'($urandom);
               default: w_m[n][k] = int'($urandom) >>> 20;
            endcase
   endtask

   task automatic clear_mon();
      wa_q.delete();
      wd_q.delete();
      done_cnt = 0;
      hold_bad = 0;
   endtask

   task automatic drive_act();
      for (int i = 0; i < N_IN; i++) act_i[32*i +: 32] = act_m[i];
   endtask

   task automatic wait_done(input int target, input int limit);
      int i = 0;
      while (done_cnt < target && i < limit) begin
         @(negedge clk_i);
         i++;
      end
      chk("done_in_time", 64'(done_cnt >= target), 64'd1);
   endtask

   task automatic check_layer(input bit relu, input int layers);
      chk("done_pulses", 64'(done_cnt), 64'(layers));
      chk("n_writes", 64'(wa_q.size()), 64'(N_OUT * layers));
      for (int i = 0; i < wa_q.size() && i < N_OUT * layers; i++) begin
         chk("wr_addr", 64'(wa_q[i]), 64'(i % N_OUT));
         chk("wr_data", 64'(wd_q[i]), 64'(ref_out(i % N_OUT, relu)));
      end
      chk("operand_hold", 64'(hold_bad), 64'd0);
      chk("start_one_cycle", 64'(start_bad), 64'd0);
   endtask

   task automatic run_layer(input bit relu, input bit poke);
      clear_mon();
      @(negedge clk_i);
      drive_act();
      relu_en_i   = relu;
      cmd_start_i = 1'b1;
      @(negedge clk_i);
      cmd_start_i = 1'b0;
      chk("busy_after_start", 64'(cmd_busy_o), 64'd1);
      chk("err_cleared", 64'(err_o), 64'd0);
      if (poke) begin
         repeat (40) @(negedge clk_i);
         cmd_start_i = 1'b1;
         relu_en_i   = ~relu;
         for (int i = 0; i < N_IN; i++) act_i[32*i +: 32] = $urandom;
         repeat (2) @(negedge clk_i);
         cmd_start_i = 1'b0;
      end
      wait_done(1, 2000);
      repeat (3) @(negedge clk_i);
      check_layer(relu, 1);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk_i);
      chk("rst_status", 64'({cmd_busy_o, cmd_done_o, err_o, wmem_rd_o, dp_start_o, out_we_o}), 64'd0);
      chk("rst_dp_regs", 64'(|{dp_a_o, dp_b_o, dp_c_o}), 64'd0);
      chk("rst_addr_data", 64'({wmem_addr_o, out_addr_o, out_data_o}), 64'd0);
      rst_i = 1'b0;

      // act 1..10, weights 1, bias 5 -> 60 on neuron 0
      randomize_layer();
      for (int i = 0; i < N_IN; i++) begin
         act_m[i]  = i + 1;
         w_m[0][i] = 1;
      end
      w_m[0][N_IN] = 5;
      run_layer(1'b1, 1'b0);
      chk("t1_sum60", 64'(get_wd(0)), 64'd60);

      // randomized layers, one with a start pulse and input churn while busy
      for (int r = 0; r < 4; r++) begin
         randomize_layer();
         run_layer(1'($urandom_range(0, 1)), r == 2);
      end

      // negative sum -7 with and without ReLU
      randomize_layer();
      for (int i = 0; i < N_IN; i++) begin
         act_m[i]  = 1;
         w_m[0][i] = 0;
      end
      w_m[0][0]    = -12;
      w_m[0][N_IN] = 5;
      run_layer(1'b1, 1'b0);
      chk("t3_relu_neg", 64'(get_wd(0)), 64'h0);
      run_layer(1'b0, 1'b0);
      chk("t3_pass_neg", 64'(get_wd(0)), 64'hFFFF_FFF9);

      // saturation at both rails
      for (int i = 0; i < N_IN; i++) act_m[i] = 32'h7FFF_FFFF;
      for (int n = 0; n < 2; n++)
         for (int k = 0; k <= N_IN; k++) w_m[n][k] = 0;
      w_m[0][0] = 32'h7FFF_FFFF;
      w_m[0][1] = 32'h7FFF_FFFF;
      w_m[1][0] = 32'h8000_0000;
      w_m[1][1] = 32'h8000_0000;
      run_layer(1'b0, 1'b0);
      chk("t4_sat_pos", 64'(get_wd(0)), 64'h7FFF_FFFF);
      chk("t4_sat_neg", 64'(get_wd(1)), 64'h8000_0000);

      // engine never goes busy (stale valid still high) -> timeout abort
      eng_mode = 1;
      clear_mon();
      @(negedge clk_i);
      cmd_start_i = 1'b1;
      @(negedge clk_i);
      cmd_start_i = 1'b0;
      wait_done(1, 400);
      chk("to_err", 64'(err_o), 64'd1);
      chk("to_cycles", 64'(last_done_cyc - last_start_cyc - 1), 64'(TO));
      repeat (3) @(negedge clk_i);
      chk("to_no_write", 64'(wa_q.size()), 64'd0);
      chk("to_done_once", 64'(done_cnt), 64'd1);
      chk("to_err_sticky", 64'(err_o), 64'd1);
      eng_mode = 0;
      randomize_layer();
      run_layer(1'b0, 1'b0);

      // start held high across two layers; dropped during the second DONE
      randomize_layer();
      clear_mon();
      @(negedge clk_i);
      drive_act();
      relu_en_i   = 1'b1;
      cmd_start_i = 1'b1;
      wait_done(1, 2000);
      repeat (2) @(negedge clk_i);
      chk("restart_on_idle", 64'(cmd_busy_o), 64'd1);
      wait_done(2, 2000);
      cmd_start_i = 1'b0;
      repeat (4) @(negedge clk_i);
      chk("no_third_layer", 64'(cmd_busy_o), 64'd0);
      check_layer(1'b1, 2);

      // reset while neuron 2 waits on the engine
      randomize_layer();
      clear_mon();
      @(negedge clk_i);
      drive_act();
      relu_en_i   = 1'b0;
      cmd_start_i = 1'b1;
      @(negedge clk_i);
      cmd_start_i = 1'b0;
      begin
         int i = 0;
         while (!(wa_q.size() == 2 && dp_busy_i) && i < 2000) begin
            @(negedge clk_i);
            i++;
         end
         chk("reach_neuron2", 64'(i < 2000), 64'd1);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("midrst_zero", 64'(|{cmd_busy_o, cmd_done_o, err_o, wmem_rd_o, wmem_addr_o, dp_a_o, dp_b_o,
                                dp_c_o, dp_start_o, out_we_o, out_addr_o, out_data_o}), 64'd0);
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("midrst_writes", 64'(wa_q.size()), 64'd2);
      chk("midrst_no_done", 64'(done_cnt), 64'd0);
      run_layer(1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
